// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } mdu_state_t;

    // v must be sign-extended from bit w-1; caller keeps the low w bits.
    function automatic logic [63:0] abs_val(input logic [63:0] v, input int unsigned w);
        abs_val = v[6'(w - 1)] ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted  = {rem, dividend_bit};
        q_bit    = (shifted >= {1'b0, divisor});
        rem_next = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle MIPS multiply/divide unit writing the HI/LO registers; one radix-2 step per clock.
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO write directly
//   CALC  | WIDTH shift-add or restoring-divide steps
//   FIXUP | sign correction, HI/LO write, done pulse
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    mdu_state_t         state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
    logic [WIDTH-1:0]   opnd_b, x_raw, abs_x, abs_y, rem_next, q_fix, r_fix;
    logic [WIDTH:0]     mul_sum;
    logic               is_div, neg_lo, neg_hi, q_bit;
    logic               start_ok, muldiv_op, signed_op, div_op;

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem          (acc[2*WIDTH-1:WIDTH]),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (opnd_b),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    always_comb begin
        muldiv_op = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
        signed_op = (op == MDU_MULT) || (op == MDU_DIV);
        div_op    = (op == MDU_DIV) || (op == MDU_DIVU);
        start_ok  = (state == IDLE) && start && !cancel;
        abs_x     = signed_op ? WIDTH'(abs_val(64'(signed'(x)), WIDTH)) : x;
        abs_y     = signed_op ? WIDTH'(abs_val(64'(signed'(y)), WIDTH)) : y;

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
        acc_step  = is_div ? {rem_next, acc[WIDTH-2:0], q_bit}
                           : {mul_sum, acc[WIDTH-1:1]};

        prod_fix  = neg_lo ? -acc : acc;
        q_fix     = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix     = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start_ok && muldiv_op) state_next = CALC;
            CALC:    if (cancel) state_next = IDLE;
                     else if (cnt == CNT_W'(WIDTH - 1)) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd_b   <= '0;
            x_raw    <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok && muldiv_op) begin
                        cnt      <= '0;
                        is_div   <= div_op;
                        x_raw    <= x;
                        opnd_b   <= div_op ? abs_y : abs_x;
                        acc      <= {{WIDTH{1'b0}}, (div_op ? abs_x : abs_y)};
                        neg_lo   <= signed_op && (x[WIDTH-1] ^ y[WIDTH-1]);
                        neg_hi   <= signed_op && x[WIDTH-1];
                        div_zero <= div_op && (y == '0);
                    end else if (start_ok && op == MDU_MTHI) begin
                        hi <= x;
                    end else if (start_ok && op == MDU_MTLO) begin
                        lo <= x;
                    end
                end
                CALC: begin
                    if (!cancel) begin
                        acc <= acc_step;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIXUP: begin
                    if (!cancel) begin
                        done <= 1'b1;
                        // Divide by zero still runs full length; the result is forced here.
                        if (is_div && div_zero) begin
                            hi <= x_raw;
                            lo <= '1;
                        end else if (is_div) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multi-cycle multiply/divide unit: the sequential companion to the combinational ALU in the MIPS datapath.
- Executes MULT/MULTU/DIV/DIVU iteratively into architectural HI/LO registers; MTHI/MTLO write them directly.
- The EX stage issues via start/busy/done; MFHI/MFLO read hi/lo combinationally and stall while busy.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits; must be ≥4 and even.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  issue request; sampled on clk only when busy=0.
- op  in  3  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO; other codes ignored.
- x  in  WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO data.
- y  in  WIDTH  rt operand: multiplier / divisor.
- cancel  in  1  abort in-flight operation (exception flush).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO receive a mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_zero  out  1  sticky flag: last DIV/DIVU had divisor 0; cleared by the next accepted mul/div.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. Reset mid-operation discards the operation.
- States:
  - IDLE→CALC: start with a mul/div op. Latch |x| and |y| (signed ops) or raw x and y (unsigned ops). Latch the result sign bits. Counter=0. busy=1 from the next cycle.
  - CALC: one radix-2 step per cycle, WIDTH cycles.
  - CALC→FIXUP: when counter==WIDTH-1.
  - FIXUP: apply sign correction, write hi/lo, pulse done=1, busy=0, then return to IDLE.
- Latency: start sampled at edge E0; hi/lo valid and done=1 after edge E(WIDTH+1). For WIDTH=32, that is 33 edges. busy=1 between E0 and E(WIDTH+1).
- Multiply: shift-add over a 2*WIDTH accumulator. Result {hi,lo} = full 2*WIDTH product. For signed ops, negate if sign(x)^sign(y).
- Divide: restoring division. lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN_INT / -1: lo=MIN_INT, hi=0, no trap.
- Divide by zero: no iteration skip, same latency. Result hi=x (original, unnegated), lo=all ones, div_zero=1.
- MTHI/MTLO with busy=0: hi (or lo) = x at the sampling edge. No busy, no done. div_zero unchanged.
- start while busy=1: ignored, no queueing.
- start with an illegal op: ignored.
- cancel=1 in CALC or FIXUP: next state IDLE, busy=0, no done, hi/lo unchanged.
- cancel in IDLE: no effect.
- cancel and start in the same cycle while IDLE: cancel has priority; start is dropped.
- done is never asserted in the same cycle as busy=1.

Decomposition:
- Package mdu_pkg holds:
  - op code localparams MDU_* (3-bit);
  - state encoding IDLE/CALC/FIXUP (2-bit);
  - a helper function abs_val(WIDTH).
- Sub-module mdu_div_step: combinational single restoring-division step, parametrised by WIDTH.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- The multiply step is inline.

Test Plan:
- MULT x=0xFFFFFFFD (-3), y=7 → done exactly 33 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=1 for the preceding 33 cycles.
- MULTU x=y=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV:
  - x=0xFFFFFFF9 (-7), y=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - x=0x80000000, y=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU x=7, y=0 → hi=7, lo=0xFFFFFFFF, div_zero=1. A following MULTU 2*3 → div_zero=0, lo=6, hi=0.
- MTLO x=0x12345678 → lo updated next edge, done=0. Then DIVU 100/7 started; second start at cycle 5 ignored; cancel at cycle 10 → busy=0, no done, lo=0x12345678, hi unchanged.
- rst_n=0 at cycle 20 of a MULT → hi=lo=0, busy=done=0 next cycle. A new DIVU 100/7 afterwards → lo=14, hi=2.
